regs_wb_arbiter: RTL and testbench

//   Shares the single register-file write port (rd_we/rd_waddr/rd_wdata) between two writeback sources.

---
 rtl/regs_wb_arbiter_if.sv | 34 +++
 rtl/regs_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_regs_wb_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regs_wb_arbiter_if.sv
// Bus bundle for the regfile writeback arbiter: EX and LD request channels, write port, LD level.
// slave is the arbiter side; master is the side that drives the requests and watches the write port.
interface regs_wb_arbiter_if #(
    parameter int unsigned LD_FIFO_DEPTH = 4
);
    localparam int unsigned LvlW = $clog2(LD_FIFO_DEPTH) + 1;

    logic            ex_valid_i;
    logic [4:0]      ex_waddr_i;
    logic [31:0]     ex_wdata_i;
    logic            ex_ready_o;
    logic            ld_valid_i;
    logic [4:0]      ld_waddr_i;
    logic [31:0]     ld_wdata_i;
    logic            ld_ready_o;
    logic            rd_we_o;
    logic [4:0]      rd_waddr_o;
    logic [31:0]     rd_wdata_o;
    logic [LvlW-1:0] ld_level_o;

    modport slave (
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  ld_valid_i, ld_waddr_i, ld_wdata_i,
        output ex_ready_o, ld_ready_o,
        output rd_we_o, rd_waddr_o, rd_wdata_o, ld_level_o
    );

    modport master (
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output ld_valid_i, ld_waddr_i, ld_wdata_i,
        input  ex_ready_o, ld_ready_o,
        input  rd_we_o, rd_waddr_o, rd_wdata_o, ld_level_o
    );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Arbitrates the single regfile write port between EX results and FIFO-buffered LD returns.
// EX wins by default; after STARVE_LIMIT EX wins with LD pending, one LD grant is forced.
module regs_wb_arbiter #(
    parameter int unsigned LD_FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regs_wb_arbiter_if.slave       bus
);
    localparam int unsigned PtrW = $clog2(LD_FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [3:0]  Limit = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {StExPrio, StLdPrio} state_e;

    state_e          state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic [LvlW-1:0] wptr_q, rptr_q, level;
    logic            full, empty, push;
    logic            ex_grant, ld_grant;
    logic            rd_we_q, rd_we_d;
    logic [4:0]      rd_waddr_q, rd_waddr_d;
    logic [31:0]     rd_wdata_q, rd_wdata_d;
    logic [4:0]      mem_waddr [LD_FIFO_DEPTH];
    logic [31:0]     mem_wdata [LD_FIFO_DEPTH];
    logic [4:0]      head_waddr;
    logic [31:0]     head_wdata;

    // Extra pointer bit makes level = wptr - rptr unambiguous at full.
    assign level      = wptr_q - rptr_q;
    assign full       = (level == LvlW'(LD_FIFO_DEPTH));
    assign empty      = (level == '0);
    assign push       = bus.ld_valid_i && !full;
    assign head_waddr = mem_waddr[rptr_q[PtrW-1:0]];
    assign head_wdata = mem_wdata[rptr_q[PtrW-1:0]];

    always_comb begin
        ex_grant   = 1'b0;
        ld_grant   = 1'b0;
        state_d    = state_q;
        starve_d   = starve_q;
        rd_we_d    = 1'b0;
        rd_waddr_d = rd_waddr_q;
        rd_wdata_d = rd_wdata_q;

        unique case (state_q)
            StExPrio: begin
                if (bus.ex_valid_i) begin
                    ex_grant = 1'b1;
                end else if (!empty) begin
                    ld_grant = 1'b1;
                end
            end
            StLdPrio: ld_grant = !empty;
            default:  ld_grant = 1'b0;
        endcase

        if (ld_grant || empty) begin
            starve_d = '0;
        end else if (ex_grant && (starve_q < Limit)) begin
            starve_d = starve_q + 4'd1;
        end

        // Switching on the next count lets LD go right after the LIMIT-th EX win.
        unique case (state_q)
            StExPrio: if (starve_d == Limit) state_d = StLdPrio;
            StLdPrio: if (ld_grant) state_d = StExPrio;
            default:  state_d = StExPrio;
        endcase

        if (ex_grant) begin
            rd_we_d    = (bus.ex_waddr_i != 5'd0);
            rd_waddr_d = bus.ex_waddr_i;
            rd_wdata_d = bus.ex_wdata_i;
        end else if (ld_grant) begin
            rd_we_d    = (head_waddr != 5'd0);
            rd_waddr_d = head_waddr;
            rd_wdata_d = head_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StExPrio;
            starve_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_we_q    <= 1'b0;
            rd_waddr_q <= '0;
            rd_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_we_q    <= rd_we_d;
            rd_waddr_q <= rd_waddr_d;
            rd_wdata_q <= rd_wdata_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (ld_grant) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_waddr[wptr_q[PtrW-1:0]] <= bus.ld_waddr_i;
            mem_wdata[wptr_q[PtrW-1:0]] <= bus.ld_wdata_i;
        end
    end

    assign bus.ex_ready_o = ex_grant;
    assign bus.ld_ready_o = !full;
    assign bus.rd_we_o    = rd_we_q;
    assign bus.rd_waddr_o = rd_waddr_q;
    assign bus.rd_wdata_o = rd_wdata_q;
    assign bus.ld_level_o = level;
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Bench for regs_wb_arbiter: directed vector table plus randomized traffic against a queue model.
module tb_regs_wb_arbiter;
    localparam int unsigned Depth = 4;
    localparam int unsigned Limit = 3;
    localparam int unsigned LvlW  = $clog2(Depth) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regs_wb_arbiter_if #(.LD_FIFO_DEPTH(Depth)) bus ();

    regs_wb_arbiter #(
        .LD_FIFO_DEPTH(Depth),
        .STARVE_LIMIT (Limit)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        bit          chk;
        logic        rst;
        logic        exv;
        logic [4:0]  exa;
        logic [31:0] exd;
        logic        ldv;
        logic [4:0]  lda;
        logic [31:0] ldd;
        logic        x_exr;
        logic        x_ldr;
        logic [LvlW-1:0] x_lvl;
        logic        x_we;
        logic [4:0]  x_wa;
        logic [31:0] x_wd;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: LD queue, count of EX wins while LD waits, and a pending forced LD turn.
    ent_t        q[$];
    int          wins = 0;
    bit          force_ld = 0;
    bit          mvalid = 0;
    logic        m_we = 0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit c, logic r, logic ev, logic [4:0] ea, logic [31:0] ed,
                                logic lv, logic [4:0] la, logic [31:0] ld, logic xer,
                                logic xlr, logic [LvlW-1:0] xl, logic xw, logic [4:0] xa,
                                logic [31:0] xd);
        vec_t v;
        v.chk = c;  v.rst = r;  v.exv = ev; v.exa = ea; v.exd = ed;
        v.ldv = lv; v.lda = la; v.ldd = ld;
        v.x_exr = xer; v.x_ldr = xlr; v.x_lvl = xl; v.x_we = xw; v.x_wa = xa; v.x_wd = xd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_n          = v.rst;
        bus.ex_valid_i = v.exv;
        bus.ex_waddr_i = v.exa;
        bus.ex_wdata_i = v.exd;
        bus.ld_valid_i = v.ldv;
        bus.ld_waddr_i = v.lda;
        bus.ld_wdata_i = v.ldd;
    endtask

    // One clock: check at negedge (table row if asked, then model), advance model past posedge.
    task automatic step(input bit tchk, input vec_t v);
        bit   g_ex, g_ld, do_push;
        ent_t head;
        int   sz;
        @(negedge clk);
        if (tchk) begin
            chk("tbl_ex_ready", 32'(bus.ex_ready_o), 32'(v.x_exr));
            chk("tbl_ld_ready", 32'(bus.ld_ready_o), 32'(v.x_ldr));
            chk("tbl_ld_level", 32'(bus.ld_level_o), 32'(v.x_lvl));
            chk("tbl_rd_we",    32'(bus.rd_we_o),    32'(v.x_we));
            chk("tbl_rd_waddr", 32'(bus.rd_waddr_o), 32'(v.x_wa));
            chk("tbl_rd_wdata", bus.rd_wdata_o,      v.x_wd);
        end
        sz   = q.size();
        g_ex = 0;
        g_ld = 0;
        if (force_ld) g_ld = 1;
        else if (bus.ex_valid_i) g_ex = 1;
        else if (sz > 0) g_ld = 1;
        if (mvalid) begin
            chk("mdl_ex_ready", 32'(bus.ex_ready_o), 32'(g_ex));
            chk("mdl_ld_ready", 32'(bus.ld_ready_o), 32'(sz < Depth));
            chk("mdl_ld_level", 32'(bus.ld_level_o), 32'(sz));
            chk("mdl_rd_we",    32'(bus.rd_we_o),    32'(m_we));
            chk("mdl_rd_waddr", 32'(bus.rd_waddr_o), 32'(m_wa));
            chk("mdl_rd_wdata", bus.rd_wdata_o,      m_wd);
        end
        if (g_ex && bus.ex_waddr_i != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].a == bus.ex_waddr_i)
                    $warning("WAW hazard: EX to x%0d with LD pending", bus.ex_waddr_i);
            end
        end
        do_push = bus.ld_valid_i && (sz < Depth);
        head    = (sz > 0) ? q[0] : '0;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            wins = 0; force_ld = 0;
            m_we = 0; m_wa = '0; m_wd = '0;
            mvalid = 1;
        end else begin
            m_we = 0;
            if (g_ex) begin
                m_we = (bus.ex_waddr_i != 5'd0); m_wa = bus.ex_waddr_i; m_wd = bus.ex_wdata_i;
            end else if (g_ld) begin
                m_we = (head.a != 5'd0); m_wa = head.a; m_wd = head.d;
            end
            if (g_ld) begin
                wins = 0; force_ld = 0;
                void'(q.pop_front());
            end else if (sz == 0) begin
                wins = 0;
            end else if (g_ex) begin
                if (wins < Limit) wins++;
                if (wins == Limit) force_ld = 1;
            end
            if (do_push) q.push_back('{a: bus.ld_waddr_i, d: bus.ld_wdata_i});
        end
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t rv;
        int   pex, pld;
        // chk rst exv exa exd   ldv lda ldd | exr ldr lvl we wa wd
        tbl.push_back(mk(0,0,0, 0,0,        0, 0,0,      0,1,0,0, 0,0));
        tbl.push_back(mk(1,0,0, 0,0,        0, 0,0,      0,1,0,0, 0,0));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,0,0, 0,0));
        tbl.push_back(mk(1,1,1, 5,32'hDEADBEEF,0,0,0,    1,1,0,0, 0,0));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,0,1, 5,32'hDEADBEEF));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,0,0, 5,32'hDEADBEEF));
        tbl.push_back(mk(1,1,1, 0,32'h55,   0, 0,0,      1,1,0,0, 5,32'hDEADBEEF));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,0,0, 0,32'h55));
        tbl.push_back(mk(1,1,1, 1,32'h101,  1, 7,32'h11, 1,1,0,0, 0,32'h55));
        tbl.push_back(mk(1,1,1, 2,32'h102,  0, 0,0,      1,1,1,1, 1,32'h101));
        tbl.push_back(mk(1,1,1, 3,32'h103,  0, 0,0,      1,1,1,1, 2,32'h102));
        tbl.push_back(mk(1,1,1, 4,32'h104,  0, 0,0,      1,1,1,1, 3,32'h103));
        tbl.push_back(mk(1,1,1, 5,32'h105,  0, 0,0,      0,1,1,1, 4,32'h104));
        tbl.push_back(mk(1,1,1, 5,32'h105,  0, 0,0,      1,1,0,1, 7,32'h11));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,0,1, 5,32'h105));
        tbl.push_back(mk(1,1,1,20,32'h300,  1, 8,32'h200,1,1,0,0, 5,32'h105));
        tbl.push_back(mk(1,1,1,20,32'h300,  1, 9,32'h201,1,1,1,1,20,32'h300));
        tbl.push_back(mk(1,1,1,20,32'h300,  1,10,32'h202,1,1,2,1,20,32'h300));
        tbl.push_back(mk(1,1,1,20,32'h300,  1,11,32'h203,1,1,3,1,20,32'h300));
        tbl.push_back(mk(1,1,1,20,32'h300,  1,12,32'h204,0,0,4,1,20,32'h300));
        tbl.push_back(mk(1,1,1,20,32'h300,  1,12,32'h204,1,1,3,1, 8,32'h200));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,0,4,1,20,32'h300));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,3,1, 9,32'h201));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,2,1,10,32'h202));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,1,1,11,32'h203));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,0,1,12,32'h204));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,0,0,12,32'h204));
        tbl.push_back(mk(1,1,1,20,32'h300,  1,13,32'h213,1,1,0,0,12,32'h204));
        tbl.push_back(mk(1,1,1,20,32'h300,  1,14,32'h214,1,1,1,1,20,32'h300));
        tbl.push_back(mk(1,1,1,20,32'h300,  1,15,32'h215,1,1,2,1,20,32'h300));
        tbl.push_back(mk(1,0,1,20,32'h300,  0, 0,0,      1,1,3,1,20,32'h300));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,0,0, 0,0));
        tbl.push_back(mk(1,1,0, 0,0,        0, 0,0,      0,1,0,0, 0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            step(tbl[i].chk, tbl[i]);
        end

        // Random traffic; EX uses x0..x15 and LD x16..x31 so no WAW pair is ever generated.
        rv = mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0);
        for (int blk = 0; blk < 8; blk++) begin
            pex = 20 + 10 * blk;
            pld = 80 - 8 * blk;
            for (int c = 0; c < 250; c++) begin
                rv.rst = ($urandom_range(0, 299) != 0);
                rv.exv = ($urandom_range(0, 99) < pex);
                rv.exa = 5'($urandom_range(0, 15));
                rv.exd = $urandom;
                rv.ldv = ($urandom_range(0, 99) < pld);
                rv.lda = 5'($urandom_range(16, 31));
                rv.ldd = $urandom;
                drive(rv);
                step(0, rv);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
